// File: rtl/sevenseg_pkg.sv
// Shared types and decode table for the seven-segment capture block.
// Segment patterns are active-low, written as {g,f,e,d,c,b,a}.
package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t SEG_HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct packed {
    logic       err;
    logic       blank;
    logic [3:0] nibble;
  } seg_dec_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic seg_dec_t seg_decode(input seg_t seg);
    seg_dec_t r;
    r.err    = 1'b1;
    r.blank  = 1'b0;
    r.nibble = 4'h0;
    if (seg == SEG_BLANK) begin
      r.err   = 1'b0;
      r.blank = 1'b1;
    end else begin
      for (int unsigned i = 0; i < 16; i++) begin
        if (seg == SEG_HEX[i]) begin
          r.err    = 1'b0;
          r.nibble = 4'(i);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sevenseg_pattern_decode.sv
// Combinational segment pattern to {nibble, blank, err} decoder.
module sevenseg_pattern_decode
  import sevenseg_pkg::*;
(
  input  seg_t       seg_i,
  output logic [3:0] nibble_o,
  output logic       blank_o,
  output logic       err_o
);

  seg_dec_t dec;

  always_comb begin
    dec      = seg_decode(seg_i);
    nibble_o = dec.nibble;
    blank_o  = dec.blank;
    err_o    = dec.err;
  end

endmodule

// File: rtl/sevenseg_capture.sv
// Seven-segment display readback: synchronise, debounce, decode, commit per digit, emit change events.
// Optional decimal-point capture is enabled with `define SEVENSEG_CAP_DP_EN.
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic [6:0]                                 seg_in,
  input  logic [DIGITS-1:0]                          dig_sel,
  output logic [4*DIGITS-1:0]                        digit_val,
  output logic [DIGITS-1:0]                          digit_blank,
  output logic [DIGITS-1:0]                          digit_err,
  output logic                                       upd_valid,
  input  logic                                       upd_ready,
  output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] upd_digit,
  output logic                                       upd_ovf
`ifdef SEVENSEG_CAP_DP_EN
  ,
  input  logic                                       seg_dp,
  output logic [DIGITS-1:0]                          digit_dp
`endif
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  seg_t              seg_s1_q, seg_s2_q, seg_prev_q;
  logic [DIGITS-1:0] sel_s1_q, sel_s2_q, sel_prev_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [4*DIGITS-1:0] val_q, val_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic [DIGITS-1:0]   err_q, err_d;

  slot_state_e      slot_q, slot_d;
  logic [IDX_W-1:0] upd_digit_q, upd_digit_d;
  logic             ovf_q, ovf_d;

  logic             sel_onehot, same, commit, changed;
  logic [IDX_W-1:0] sel_idx;
  logic [3:0]       dec_nibble;
  logic             dec_blank, dec_err;

`ifdef SEVENSEG_CAP_DP_EN
  logic              dp_s1_q, dp_s2_q, dp_prev_q;
  logic [DIGITS-1:0] dp_q, dp_d;
`endif

  sevenseg_pattern_decode u_dec (
    .seg_i    (seg_s2_q),
    .nibble_o (dec_nibble),
    .blank_o  (dec_blank),
    .err_o    (dec_err)
  );

  always_comb begin
    sel_onehot = (sel_s2_q != '0) && ((sel_s2_q & (sel_s2_q - DIGITS'(1))) == '0);
    same       = sel_onehot && (seg_s2_q == seg_prev_q) && (sel_s2_q == sel_prev_q);
`ifdef SEVENSEG_CAP_DP_EN
    same       = same && (dp_s2_q == dp_prev_q);
`endif
    if (same) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end else begin
      cnt_d = sel_onehot ? CNT_W'(1) : '0;
    end
    // A saturated count that merely holds is the same run; a fresh run reaching the max commits.
    commit = (cnt_d == CNT_MAX) && !(same && (cnt_q == CNT_MAX));
  end

  always_comb begin
    val_d   = val_q;
    blank_d = blank_q;
    err_d   = err_q;
    changed = 1'b0;
    sel_idx = '0;
`ifdef SEVENSEG_CAP_DP_EN
    dp_d    = dp_q;
`endif
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (sel_s2_q[i]) begin
        sel_idx = sel_idx | IDX_W'(i);
        if (commit) begin
          if ({val_q[4*i +: 4], blank_q[i], err_q[i]} != {dec_nibble, dec_blank, dec_err}) begin
            changed = 1'b1;
          end
          val_d[4*i +: 4] = dec_nibble;
          blank_d[i]      = dec_blank;
          err_d[i]        = dec_err;
`ifdef SEVENSEG_CAP_DP_EN
          // digit_dp is held active-high: 1 means the point was lit.
          if (dp_q[i] != ~dp_s2_q) changed = 1'b1;
          dp_d[i] = ~dp_s2_q;
`endif
        end
      end
    end
  end

  always_comb begin
    slot_d      = slot_q;
    upd_digit_d = upd_digit_q;
    ovf_d       = ovf_q;
    unique case (slot_q)
      SLOT_EMPTY: begin
        if (changed) begin
          slot_d      = SLOT_FULL;
          upd_digit_d = sel_idx;
        end
      end
      SLOT_FULL: begin
        if (upd_ready) begin
          if (changed) upd_digit_d = sel_idx;
          else         slot_d      = SLOT_EMPTY;
        end else if (changed) begin
          ovf_d = 1'b1;
        end
      end
      default: slot_d = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_s1_q    <= '0;
      seg_s2_q    <= '0;
      seg_prev_q  <= '0;
      sel_s1_q    <= '0;
      sel_s2_q    <= '0;
      sel_prev_q  <= '0;
      cnt_q       <= '0;
      val_q       <= '0;
      blank_q     <= '1;
      err_q       <= '0;
      slot_q      <= SLOT_EMPTY;
      upd_digit_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      seg_s1_q    <= seg_in;
      seg_s2_q    <= seg_s1_q;
      seg_prev_q  <= seg_s2_q;
      sel_s1_q    <= dig_sel;
      sel_s2_q    <= sel_s1_q;
      sel_prev_q  <= sel_s2_q;
      cnt_q       <= cnt_d;
      val_q       <= val_d;
      blank_q     <= blank_d;
      err_q       <= err_d;
      slot_q      <= slot_d;
      upd_digit_q <= upd_digit_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef SEVENSEG_CAP_DP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dp_s1_q   <= 1'b0;
      dp_s2_q   <= 1'b0;
      dp_prev_q <= 1'b0;
      dp_q      <= '0;
    end else begin
      dp_s1_q   <= seg_dp;
      dp_s2_q   <= dp_s1_q;
      dp_prev_q <= dp_s2_q;
      dp_q      <= dp_d;
    end
  end

  assign digit_dp = dp_q;
`endif

  assign digit_val   = val_q;
  assign digit_blank = blank_q;
  assign digit_err   = err_q;
  assign upd_valid   = (slot_q == SLOT_FULL);
  assign upd_digit   = upd_digit_q;
  assign upd_ovf     = ovf_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed-vector bench for sevenseg_capture (default build, DIGITS=4, STABLE_CYCLES=4).
module tb_sevenseg_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  seg_in;
  logic [3:0]  dig_sel;
  logic [15:0] digit_val;
  logic [3:0]  digit_blank;
  logic [3:0]  digit_err;
  logic        upd_valid;
  logic        upd_ready;
  logic [1:0]  upd_digit;
  logic        upd_ovf;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  sevenseg_capture #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .digit_val   (digit_val),
    .digit_blank (digit_blank),
    .digit_err   (digit_err),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .upd_digit   (upd_digit),
    .upd_ovf     (upd_ovf)
  );

  typedef struct {
    logic [3:0]  sel;
    logic [6:0]  seg;
    logic        rdy;
    int unsigned cyc;
    logic [15:0] val;
    logic [3:0]  blank;
    logic [3:0]  err;
    logic        vld;
    logic [1:0]  dig;
    logic        ovf;
  } vec_t;

  localparam int unsigned NVEC = 16;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] val, input logic [3:0] blank,
                         input logic [3:0] err, input logic vld, input logic [1:0] dig,
                         input logic ovf);
    chk({tag, " digit_val"},   32'(digit_val),   32'(val));
    chk({tag, " digit_blank"}, 32'(digit_blank), 32'(blank));
    chk({tag, " digit_err"},   32'(digit_err),   32'(err));
    chk({tag, " upd_valid"},   32'(upd_valid),   32'(vld));
    chk({tag, " upd_digit"},   32'(upd_digit),   32'(dig));
    chk({tag, " upd_ovf"},     32'(upd_ovf),     32'(ovf));
  endtask

  task automatic drive(input logic [3:0] sel, input logic [6:0] seg, input logic rdy,
                       input int unsigned cyc);
    dig_sel   = sel;
    seg_in    = seg;
    upd_ready = rdy;
    repeat (cyc) @(negedge clk);
  endtask

  initial begin
    // sel, seg, rdy, cycles | val, blank, err, valid, digit, ovf
    vecs[0]  = '{4'b0001, 7'b0100100, 1'b0, 5,  16'h0000, 4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[1]  = '{4'b0001, 7'b0100100, 1'b0, 1,  16'h0002, 4'b1110, 4'b0000, 1'b1, 2'd0, 1'b0};
    vecs[2]  = '{4'b0001, 7'b0100100, 1'b0, 8,  16'h0002, 4'b1110, 4'b0000, 1'b1, 2'd0, 1'b0};
    vecs[3]  = '{4'b0000, 7'b0100100, 1'b1, 3,  16'h0002, 4'b1110, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[4]  = '{4'b0001, 7'b0100100, 1'b1, 8,  16'h0002, 4'b1110, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[5]  = '{4'b0001, 7'b1111111, 1'b0, 8,  16'h0000, 4'b1111, 4'b0000, 1'b1, 2'd0, 1'b0};
    vecs[6]  = '{4'b0000, 7'b1111111, 1'b1, 2,  16'h0000, 4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[7]  = '{4'b0010, 7'b0101010, 1'b0, 8,  16'h0000, 4'b1101, 4'b0010, 1'b1, 2'd1, 1'b0};
    vecs[8]  = '{4'b0110, 7'b0100100, 1'b1, 10, 16'h0000, 4'b1101, 4'b0010, 1'b0, 2'd1, 1'b0};
    vecs[9]  = '{4'b0001, 7'b1111000, 1'b0, 8,  16'h0007, 4'b1100, 4'b0010, 1'b1, 2'd0, 1'b0};
    vecs[10] = '{4'b0010, 7'b0110000, 1'b0, 8,  16'h0037, 4'b1100, 4'b0000, 1'b1, 2'd0, 1'b1};
    vecs[11] = '{4'b0000, 7'b0110000, 1'b1, 1,  16'h0037, 4'b1100, 4'b0000, 1'b0, 2'd0, 1'b1};
    vecs[12] = '{4'b1000, 7'b0001110, 1'b0, 8,  16'hF037, 4'b0100, 4'b0000, 1'b1, 2'd3, 1'b1};
    vecs[13] = '{4'b0100, 7'b0001000, 1'b0, 5,  16'hF037, 4'b0100, 4'b0000, 1'b1, 2'd3, 1'b1};
    vecs[14] = '{4'b0100, 7'b0001000, 1'b1, 1,  16'hFA37, 4'b0000, 4'b0000, 1'b1, 2'd2, 1'b1};
    vecs[15] = '{4'b0000, 7'b0001000, 1'b1, 1,  16'hFA37, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b1};

    reset_n   = 1'b0;
    seg_in    = '0;
    dig_sel   = '0;
    upd_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_all("reset", 16'h0000, 4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int unsigned i = 0; i < NVEC; i++) begin
      drive(vecs[i].sel, vecs[i].seg, vecs[i].rdy, vecs[i].cyc);
      chk_all($sformatf("vec%0d", i), vecs[i].val, vecs[i].blank, vecs[i].err,
              vecs[i].vld, vecs[i].dig, vecs[i].ovf);
    end

    // Glitch: three runs of three samples each never reach the stability threshold.
    drive(4'b0001, 7'b0010010, 1'b1, 3);
    drive(4'b0001, 7'b0000000, 1'b1, 3);
    drive(4'b0001, 7'b0010010, 1'b1, 3);
    chk_all("glitch", 16'hFA37, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b1);
    drive(4'b0001, 7'b0010010, 1'b0, 8);
    chk_all("post_glitch", 16'hFA35, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b1);

    // Reset mid-run with an event pending.
    drive(4'b0010, 7'b0011000, 1'b0, 3);
    reset_n = 1'b0;
    #1;
    chk_all("mid_reset", 16'h0000, 4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int unsigned c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("post_reset c%0d upd_valid", c), 32'(upd_valid), 32'd0);
      chk($sformatf("post_reset c%0d digit_val", c), 32'(digit_val), 32'h0);
    end
    @(negedge clk);
    chk_all("post_reset commit", 16'h0090, 4'b1101, 4'b0000, 1'b1, 2'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
